camera_pixel_capture: RTL and testbench

CAMERA_PIXEL_CAPTURE -- requirements
Module: camera_pixel_capture

---
 rtl/camera_pixel_capture_pkg.sv | 14 +
 rtl/camera_pixel_capture_edge_detect.sv | 24 ++
 rtl/camera_pixel_capture.sv | 128 ++++++++++++
 tb/tb_camera_pixel_capture.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pixel_capture_pkg.sv
// Shared capture types: FSM state encoding and RGB444 pixel width.
// Also imported by the framebuffer side.
package camera_pixel_capture_pkg;

    localparam int PIXEL_W = 12;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        WAIT_LINE  = 2'd1,
        BYTE_HI    = 2'd2,
        BYTE_LO    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/camera_pixel_capture_edge_detect.sv
// Rise/fall pulse generator: compares the input against its registered copy.
// Pulses are valid in the same cycle the new level is seen.
module camera_pixel_capture_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/camera_pixel_capture.sv
// DVP-style camera byte stream to RGB444 pixel strobes.
// Two bytes per pixel; frame and line framing from vsync/href edges.
module camera_pixel_capture
    import camera_pixel_capture_pkg::*;
#(
    parameter int FRAME_WIDTH  = 240,
    parameter int FRAME_HEIGHT = 320
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cam_pclk,
    input  logic               cam_vsync,
    input  logic               cam_href,
    input  logic [7:0]         cam_data,
    output logic               axiov,
    output logic [PIXEL_W-1:0] axiod,
    output logic               frame_done,
    output logic [15:0]        line_y,
    output logic [15:0]        pixel_x
);

    localparam logic [15:0] W_LIM = 16'(FRAME_WIDTH);
    localparam logic [15:0] H_LIM = 16'(FRAME_HEIGHT);

    logic w_pclk_rise;
    logic w_pclk_fall_unused;
    logic w_vs_rise;
    logic w_vs_fall;
    logic w_href_rise_unused;
    logic w_href_fall;
    logic w_sample;
    logic w_visible;

    cap_state_t         r_state;
    logic [3:0]         r_hi;
    logic               r_axiov;
    logic [PIXEL_W-1:0] r_axiod;
    logic               r_frame_done;
    logic [15:0]        r_line_y;
    logic [15:0]        r_pixel_x;

    camera_pixel_capture_edge_detect u_pclk_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (cam_pclk),
        .o_rise (w_pclk_rise),
        .o_fall (w_pclk_fall_unused)
    );

    camera_pixel_capture_edge_detect u_vsync_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (cam_vsync),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    camera_pixel_capture_edge_detect u_href_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (cam_href),
        .o_rise (w_href_rise_unused),
        .o_fall (w_href_fall)
    );

    assign w_sample  = w_pclk_rise & cam_href;
    assign w_visible = (r_pixel_x < W_LIM) && (r_line_y < H_LIM);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= WAIT_FRAME;
            r_hi         <= 4'd0;
            r_axiov      <= 1'b0;
            r_axiod      <= '0;
            r_frame_done <= 1'b0;
            r_line_y     <= 16'd0;
            r_pixel_x    <= 16'd0;
        end else begin
            r_axiov      <= 1'b0;
            r_frame_done <= 1'b0;
            // End of frame outranks any pixel finishing in the same cycle
            if (w_vs_rise && (r_state != WAIT_FRAME)) begin
                r_frame_done <= 1'b1;
                r_state      <= WAIT_FRAME;
            end else begin
                unique case (r_state)
                    WAIT_FRAME: begin
                        if (w_vs_fall) begin
                            r_state   <= WAIT_LINE;
                            r_line_y  <= 16'd0;
                            r_pixel_x <= 16'd0;
                        end
                    end
                    WAIT_LINE: begin
                        if (w_sample) begin
                            r_hi    <= cam_data[3:0];
                            r_state <= BYTE_LO;
                        end
                    end
                    BYTE_HI, BYTE_LO: begin
                        if (w_href_fall) begin
                            r_state   <= WAIT_LINE;
                            r_pixel_x <= 16'd0;
                            if ((r_pixel_x != 16'd0) && (r_line_y != 16'hFFFF))
                                r_line_y <= r_line_y + 16'd1;
                        end else if (w_sample && (r_state == BYTE_HI)) begin
                            r_hi    <= cam_data[3:0];
                            r_state <= BYTE_LO;
                        end else if (w_sample) begin
                            r_axiov <= w_visible;
                            r_axiod <= {r_hi, cam_data};
                            r_state <= BYTE_HI;
                            if (r_pixel_x != 16'hFFFF)
                                r_pixel_x <= r_pixel_x + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign axiov      = r_axiov;
    assign axiod      = r_axiod;
    assign frame_done = r_frame_done;
    assign line_y     = r_line_y;
    assign pixel_x    = r_pixel_x;

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Scoreboard bench for camera_pixel_capture (FRAME_WIDTH=4, FRAME_HEIGHT=3).
// Stimulus pushes expected pixels; a negedge monitor pops and compares.
module tb_camera_pixel_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        cam_pclk;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        axiov;
    logic [11:0] axiod;
    logic        frame_done;
    logic [15:0] line_y;
    logic [15:0] pixel_x;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    camera_pixel_capture #(
        .FRAME_WIDTH  (4),
        .FRAME_HEIGHT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .axiov      (axiov),
        .axiod      (axiod),
        .frame_done (frame_done),
        .line_y     (line_y),
        .pixel_x    (pixel_x)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt++;
            chk("fd_no_axiov", {31'd0, axiov}, 32'd0);
        end
        if (axiov) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pixel: got %0h expected none", axiod);
            end else begin
                chk("axiod", {20'd0, axiod}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        tick(2);
        cam_pclk = 1'b1;
        tick(2);
        cam_pclk = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo,
                              input logic keep);
        logic [3:0] nib;
        send_byte(hi);
        nib = hi[3:0];
        cam_data = lo;
        cam_pclk = 1'b0;
        tick(2);
        if (keep) exp_q.push_back({nib, lo});
        cam_pclk = 1'b1;
        tick(1);
        chk("axiov_latency", {31'd0, axiov}, {31'd0, keep});
        tick(1);
        chk("axiov_one_cycle", {31'd0, axiov}, 32'd0);
        cam_pclk = 1'b0;
    endtask

    task automatic send_line(input int npix, input int nkeep, input int seed);
        cam_href = 1'b1;
        tick(2);
        for (int p = 0; p < npix; p++)
            send_pixel(8'(8'hE0 + seed + p * 3), 8'(seed * 7 + p * 29 + 1),
                       p < nkeep);
        cam_href = 1'b0;
        tick(3);
    endtask

    initial begin
        rst       = 1'b0;
        cam_pclk  = 1'b0;
        cam_vsync = 1'b1;
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        @(posedge clk);
        #1;
        tick(2);
        chk("rst_axiov", {31'd0, axiov}, 32'd0);
        chk("rst_axiod", {20'd0, axiod}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_line_y", {16'd0, line_y}, 32'd0);
        chk("rst_pixel_x", {16'd0, pixel_x}, 32'd0);
        rst = 1'b1;
        tick(2);

        // bytes before the first vsync fall are ignored
        cam_href = 1'b1;
        tick(2);
        send_pixel(8'h12, 8'h34, 1'b0);
        cam_href = 1'b0;
        tick(2);
        chk("pre_frame_fd", fd_cnt, 0);
        chk("pre_frame_px", {16'd0, pixel_x}, 32'd0);

        // basic two-pixel line
        cam_vsync = 1'b0;
        tick(3);
        cam_href = 1'b1;
        tick(2);
        send_pixel(8'h0A, 8'hBC, 1'b1);
        send_pixel(8'h05, 8'h67, 1'b1);
        tick(2);
        chk("t1_pixel_x", {16'd0, pixel_x}, 32'd2);
        cam_href = 1'b0;
        tick(3);
        chk("t1_line_y", {16'd0, line_y}, 32'd1);
        chk("t1_px_clear", {16'd0, pixel_x}, 32'd0);
        cam_vsync = 1'b1;
        tick(3);
        chk("t1_fd", fd_cnt, 1);

        // three full lines then end of frame
        cam_vsync = 1'b0;
        tick(3);
        chk("t2_line_y0", {16'd0, line_y}, 32'd0);
        for (int l = 0; l < 3; l++)
            send_line(4, 4, 16 * l + 2);
        cam_vsync = 1'b1;
        tick(3);
        chk("t2_line_y", {16'd0, line_y}, 32'd3);
        chk("t2_fd", fd_cnt, 2);
        chk("t2_q_empty", exp_q.size(), 0);

        // width limit, empty line, odd bytes, height limit
        cam_vsync = 1'b0;
        tick(3);
        cam_href = 1'b1;
        tick(2);
        for (int p = 0; p < 6; p++)
            send_pixel(8'(8'h50 + p), 8'(8'h90 + 8 * p), p < 4);
        tick(2);
        chk("t3_pixel_x6", {16'd0, pixel_x}, 32'd6);
        cam_href = 1'b0;
        tick(3);
        chk("t3_line_y1", {16'd0, line_y}, 32'd1);
        cam_href = 1'b1;
        tick(3);
        cam_href = 1'b0;
        tick(3);
        chk("t3_empty_line", {16'd0, line_y}, 32'd1);
        cam_href = 1'b1;
        tick(2);
        send_pixel(8'hC1, 8'h22, 1'b1);
        send_pixel(8'hD3, 8'h44, 1'b1);
        send_byte(8'h7F);
        cam_href = 1'b0;
        tick(3);
        chk("t3_odd_line_y", {16'd0, line_y}, 32'd2);
        send_line(1, 1, 9);
        chk("t3_line_y3", {16'd0, line_y}, 32'd3);
        send_line(2, 0, 5);
        chk("t3_line_y4", {16'd0, line_y}, 32'd4);
        chk("t3_q_empty", exp_q.size(), 0);
        cam_vsync = 1'b1;
        tick(3);
        chk("t3_fd", fd_cnt, 3);

        // vsync rise coincides with low-byte sample
        cam_vsync = 1'b0;
        tick(3);
        cam_href = 1'b1;
        tick(2);
        send_byte(8'h9E);
        cam_data = 8'h44;
        cam_pclk = 1'b0;
        tick(2);
        cam_pclk  = 1'b1;
        cam_vsync = 1'b1;
        tick(1);
        chk("t4_axiov", {31'd0, axiov}, 32'd0);
        chk("t4_frame_done", {31'd0, frame_done}, 32'd1);
        tick(1);
        chk("t4_fd_pulse", {31'd0, frame_done}, 32'd0);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        tick(3);
        chk("t4_fd", fd_cnt, 4);

        // reset mid-line
        cam_vsync = 1'b0;
        tick(3);
        cam_href = 1'b1;
        tick(2);
        send_pixel(8'h3A, 8'h5B, 1'b1);
        send_byte(8'h3C);
        rst = 1'b0;
        tick(1);
        chk("t5_axiov", {31'd0, axiov}, 32'd0);
        chk("t5_axiod", {20'd0, axiod}, 32'd0);
        chk("t5_frame_done", {31'd0, frame_done}, 32'd0);
        chk("t5_line_y", {16'd0, line_y}, 32'd0);
        chk("t5_pixel_x", {16'd0, pixel_x}, 32'd0);
        rst = 1'b1;
        tick(1);
        send_pixel(8'h11, 8'h22, 1'b0);
        cam_href = 1'b0;
        tick(3);
        chk("t5_ignored_px", {16'd0, pixel_x}, 32'd0);
        cam_vsync = 1'b1;
        tick(3);
        chk("t5_no_fd", fd_cnt, 4);
        cam_vsync = 1'b0;
        tick(3);
        send_line(1, 1, 3);
        chk("t5_resume_line", {16'd0, line_y}, 32'd1);
        tick(2);
        chk("final_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
